bitstream_decoder: RTL and testbench



---
 rtl/bitstream_pkg.sv | 15 +
 rtl/window_counter.sv | 28 ++
 rtl/bitstream_decoder.sv | 100 ++++++++++
 tb/tb_bitstream_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_pkg.sv
// rtl/bitstream_pkg.sv - shared types and mode constants for the bitstream stages
package bitstream_pkg;

    // Conversion state shared by the bitstream decoder and its sibling stages
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } bs_state_t;

    // Result encodings selectable through the BIPOLAR parameter
    localparam int MODE_UNIPOLAR = 0;
    localparam int MODE_BIPOLAR  = 1;

endpackage

// File: rtl/window_counter.sv
// rtl/window_counter.sv - WIDTH-bit window counter with clear, enable and last-cycle flag
module window_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [WIDTH-1:0] count;

    // The final position of the window is the all-ones count; advancing past it wraps to 0
    assign last = &count;

    // Clear has priority so a new window always starts from position 0
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bitstream_decoder.sv
// rtl/bitstream_decoder.sv - counts ones of a stochastic bitstream over a 2^WIDTH window
module bitstream_decoder
    import bitstream_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int BIPOLAR = MODE_UNIPOLAR
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             x,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH+1:0] result
);

    localparam int               WINDOW_LEN = 1 << WIDTH;
    localparam logic [WIDTH+1:0] WINDOW_W   = (WIDTH+2)'(WINDOW_LEN);

    bs_state_t        state;
    logic [WIDTH:0]   ones;
    logic [WIDTH:0]   ones_final;
    logic [WIDTH+1:0] formatted;
    logic             accept_start;
    logic             wc_last;

    // Count including the current sample, so the last sample lands in the result
    assign ones_final = ones + {{WIDTH{1'b0}}, x};

    // A start is honoured from IDLE, or from HOLD together with the result handshake
    assign accept_start = start && ((state == IDLE) || ((state == HOLD) && ready));

    // Result encoding is fixed at elaboration time
    generate
        if (BIPOLAR == MODE_BIPOLAR) begin : g_bipolar
            assign formatted = {ones_final, 1'b0} - WINDOW_W;
        end else begin : g_unipolar
            assign formatted = {1'b0, ones_final};
        end
    endgenerate

    window_counter #(
        .WIDTH (WIDTH)
    ) u_window_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (accept_start),
        .en    (state == COUNT),
        .last  (wc_last)
    );

    // Conversion FSM with registered busy/valid/result and the ones accumulator
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
            ones   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                        ones  <= '0;
                    end
                end
                COUNT: begin
                    ones <= ones_final;
                    if (wc_last) begin
                        state  <= HOLD;
                        busy   <= 1'b0;
                        valid  <= 1'b1;
                        result <= formatted;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (start) begin
                            state <= COUNT;
                            busy  <= 1'b1;
                            ones  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_decoder.sv
// tb/tb_bitstream_decoder.sv - randomized self-checking bench for bitstream_decoder
module tb_bitstream_decoder;

    localparam int W   = 4;
    localparam int WIN = 1 << W;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       x = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic       busy_u, valid_u, busy_b, valid_b;
    logic [W+1:0] result_u, result_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitstream_decoder #(.WIDTH(W), .BIPOLAR(0)) u_uni (
        .clk(clk), .n_rst(n_rst), .x(x), .start(start),
        .busy(busy_u), .valid(valid_u), .ready(ready), .result(result_u)
    );

    bitstream_decoder #(.WIDTH(W), .BIPOLAR(1)) u_bip (
        .clk(clk), .n_rst(n_rst), .x(x), .start(start),
        .busy(busy_b), .valid(valid_b), .ready(ready), .result(result_b)
    );

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Behavioural model: collect the samples of the current window and sum them when full
    logic       m_busy = 1'b0;
    logic       m_valid = 1'b0;
    logic [W+1:0] m_res_u = '0;
    logic [W+1:0] m_res_b = '0;
    logic       samples[$];

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_res_u <= '0;
            m_res_b <= '0;
            samples.delete();
        end else if (m_busy) begin
            samples.push_back(x);
            if (samples.size() == WIN) begin
                int n_ones;
                n_ones = 0;
                foreach (samples[i]) n_ones += int'(samples[i]);
                m_res_u <= (W+2)'(n_ones);
                m_res_b <= (W+2)'(2 * n_ones - WIN);
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
            end
        end else if (m_valid) begin
            if (ready) begin
                m_valid <= 1'b0;
                if (start) begin
                    m_busy <= 1'b1;
                    samples.delete();
                end
            end
        end else if (start) begin
            m_busy <= 1'b1;
            samples.delete();
        end
    end

    // Compare both DUTs against the model every cycle while out of reset
    always @(negedge clk) begin
        if (n_rst) begin
            chk("busy_u", int'(busy_u), int'(m_busy));
            chk("valid_u", int'(valid_u), int'(m_valid));
            chk("result_u", int'(result_u), int'(m_res_u));
            chk("busy_b", int'(busy_b), int'(m_busy));
            chk("valid_b", int'(valid_b), int'(m_valid));
            chk("result_b", int'(result_b), int'(m_res_b));
        end
    end

    task automatic step(input logic xv, input logic sv, input logic rv);
        x = xv;
        start = sv;
        ready = rv;
        @(posedge clk);
        #2;
    endtask

    // Sample value presented for edge E_k of a window under a named pattern
    function automatic logic xgen(input int pid, input int k);
        case (pid)
            0: return 1'b1;
            1: return 1'b0;
            2: return (k % 2) == 1;
            3: return k <= 5;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Feed edges E1.. until valid appears; lat is the edge number where it rose
    task automatic wait_window(input int pid, output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (lat == 0) begin
                step(xgen(pid, k), (pid == 4) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
                if (valid_u) lat = k;
            end
        end
        if (lat == 0) chk("window_timeout", 0, WIN);
    endtask

    task automatic run_window(input int pid, input logic x0, output int lat);
        step(x0, 1'b1, 1'b0);
        wait_window(pid, lat);
    endtask

    task automatic release_result();
        step(1'b0, 1'b0, 1'b1);
        chk("valid_drop", int'(valid_u), 0);
        chk("busy_after_release", int'(busy_u), 0);
    endtask

    initial begin
        int lat;
        logic [W+1:0] held;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_busy", int'(busy_u), 0);
        chk("reset_valid", int'(valid_u), 0);
        chk("reset_result_u", int'(result_u), 0);
        chk("reset_result_b", int'(result_b), 0);
        n_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // All ones: full count without wrap, busy throughout the window
        step(1'b1, 1'b1, 1'b0);
        chk("busy_rise", int'(busy_u), 1);
        wait_window(0, lat);
        chk("latency_ones", lat, 16);
        chk("ones_u", int'(result_u), 16);
        chk("ones_b", int'(result_b), 16);
        release_result();

        // All zeros: bipolar gives -16
        run_window(1, 1'b0, lat);
        chk("zeros_u", int'(result_u), 0);
        chk("zeros_b", int'(result_b), 6'b110000);
        release_result();

        // Alternating with a one at E0 that must not be counted
        run_window(2, 1'b1, lat);
        chk("latency_alt", lat, 16);
        chk("alt_u", int'(result_u), 8);
        chk("alt_b", int'(result_b), 0);

        // Backpressure: result held, starts ignored without ready
        held = result_u;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i % 3) == 0, 1'b0);
            chk("bp_valid", int'(valid_u), 1);
            chk("bp_busy", int'(busy_u), 0);
            chk("bp_result", int'(result_u), int'(held));
        end
        release_result();

        // Back-to-back: handshake with start goes straight into counting
        run_window(0, 1'b0, lat);
        step(1'b0, 1'b1, 1'b1);
        chk("b2b_busy", int'(busy_u), 1);
        chk("b2b_valid", int'(valid_u), 0);
        wait_window(3, lat);
        chk("b2b_latency", lat, 16);
        chk("b2b_u", int'(result_u), 5);
        chk("b2b_b", int'(result_b), 6'b111010);
        release_result();

        // Reset in the middle of a window discards it immediately
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        chk("rst_busy", int'(busy_u), 0);
        chk("rst_valid", int'(valid_u), 0);
        chk("rst_result", int'(result_u), 0);
        chk("rst_result_b", int'(result_b), 0);
        step(1'b1, 1'b1, 1'b0);
        n_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        run_window(3, 1'b1, lat);
        chk("post_rst_latency", lat, 16);
        chk("post_rst_u", int'(result_u), 5);
        release_result();

        // Randomized windows with random starts, stalls and back-to-back handshakes
        for (int r = 0; r < 8; r++) begin
            run_window(4, 1'($urandom_range(0, 1)), lat);
            chk("rand_latency", lat, 16);
            for (int d = $urandom_range(0, 4); d > 0; d--)
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                step(1'b0, 1'b1, 1'b1);
                chk("rand_b2b_busy", int'(busy_u), 1);
                wait_window(4, lat);
                chk("rand_b2b_latency", lat, 16);
            end
            release_result();
            for (int d = $urandom_range(0, 3); d > 0; d--)
                step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
